// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter feeding a one-entry output register.
// Ports: clk, reset (sync, active-high); req0/req1 with words w0/w1;
// gnt0/gnt1 one-cycle acknowledges; sel/en mux controls for this cycle;
// f/f_valid registered output word, drained by f_ready.
module mux2_arbiter #(
    parameter int N = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [2**N-1:0]   w0,
    input  logic [2**N-1:0]   w1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              sel,
    output logic              en,
    output logic [2**N-1:0]   f,
    output logic              f_valid,
    input  logic              f_ready
);

    localparam int W = 2**N;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic           last_q;
    logic [W-1:0]   f_q;

    logic           can_load;
    logic           winner;
    logic           load;
    logic           xfer;

    // Arbitration: a tie goes to whoever did not win last time.
    always_comb begin
        winner = 1'b0;
        unique case (1'b1)
            (req0 && req1):  winner = ~last_q;
            (req1 && !req0): winner = 1'b1;
            default:         winner = 1'b0;
        endcase
    end

    // A slot is free when empty, or when the held word leaves this edge.
    // Reset gates the load so nothing is granted while it is high.
    always_comb begin
        can_load = (state_q == EMPTY) || f_ready;
        load     = (req0 || req1) && can_load && !reset;
        xfer     = (state_q == FULL) && f_ready;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = FULL;
        end else if (xfer) begin
            state_d = EMPTY;
        end
    end

    // Output logic
    always_comb begin
        en      = load;
        sel     = load && winner;
        gnt0    = load && !winner;
        gnt1    = load && winner;
        f_valid = (state_q == FULL);
        f       = f_q;
    end

    // Datapath: output word and round-robin history.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_q    <= '0;
            last_q <= 1'b1;
        end else if (load) begin
            f_q    <= winner ? w1 : w0;
            last_q <= winner;
        end
    end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Bench for mux2_arbiter: directed vector table, corner sequences,
// then random traffic against a queue-based reference model.
module tb_mux2_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [7:0] w0, w1;
    logic       gnt0, gnt1, sel, en;
    logic [7:0] f;
    logic       f_valid;
    logic       f_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux2_arbiter #(.N(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .req1    (req1),
        .w0      (w0),
        .w1      (w1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .sel     (sel),
        .en      (en),
        .f       (f),
        .f_valid (f_valid),
        .f_ready (f_ready)
    );

    typedef struct {
        logic       rst;
        logic       r0;
        logic       r1;
        logic [7:0] a;
        logic [7:0] b;
        logic       rdy;
        logic       g0;
        logic       g1;
        logic       en;
        logic       sel;
        logic [7:0] f;
        logic       fv;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(logic rst, logic r0, logic r1,
                                logic [7:0] a, logic [7:0] b, logic rdy,
                                logic g0, logic g1, logic e, logic s,
                                logic [7:0] ef, logic efv);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.r1 = r1; v.a = a; v.b = b; v.rdy = rdy;
        v.g0 = g0; v.g1 = g1; v.en = e; v.sel = s; v.f = ef; v.fv = efv;
        return v;
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    // One cycle: drive after the edge, check before the next one.
    task automatic apply(vec_t v, string tag);
        @(posedge clk);
        #1;
        reset = v.rst; req0 = v.r0; req1 = v.r1;
        w0 = v.a; w1 = v.b; f_ready = v.rdy;
        @(negedge clk);
        chk({tag, ".gnt0"}, {7'd0, gnt0}, {7'd0, v.g0});
        chk({tag, ".gnt1"}, {7'd0, gnt1}, {7'd0, v.g1});
        chk({tag, ".en"}, {7'd0, en}, {7'd0, v.en});
        chk({tag, ".sel"}, {7'd0, sel}, {7'd0, v.sel});
        chk({tag, ".f"}, f, v.f);
        chk({tag, ".f_valid"}, {7'd0, f_valid}, {7'd0, v.fv});
    endtask

    // Reference model: output slot as a queue of at most one word.
    logic [7:0] mq[$];
    logic [7:0] m_f;
    logic       m_last;

    initial begin
        reset = 1'b1; req0 = 0; req1 = 0; w0 = 0; w1 = 0; f_ready = 0;
        repeat (2) @(posedge clk);

        //              rst r0 r1 w0     w1     rdy g0 g1 en sel f      fv
        tbl[0]  = mk(1, 1, 1, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0);
        tbl[1]  = mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0);
        tbl[2]  = mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0);
        tbl[3]  = mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0);
        tbl[4]  = mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0);
        tbl[5]  = mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0);
        tbl[6]  = mk(0, 1, 0, 8'hA5, 8'h00, 1, 1, 0, 1, 0, 8'h00, 0);
        tbl[7]  = mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'hA5, 1);
        tbl[8]  = mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'hA5, 0);
        tbl[9]  = mk(1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'hA5, 0);
        tbl[10] = mk(0, 1, 1, 8'h11, 8'h22, 1, 1, 0, 1, 0, 8'h00, 0);
        tbl[11] = mk(0, 1, 1, 8'h11, 8'h22, 1, 0, 1, 1, 1, 8'h11, 1);
        tbl[12] = mk(0, 1, 1, 8'h11, 8'h22, 1, 1, 0, 1, 0, 8'h22, 1);
        tbl[13] = mk(0, 1, 1, 8'h11, 8'h22, 1, 0, 1, 1, 1, 8'h11, 1);
        tbl[14] = mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h22, 1);
        tbl[15] = mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h22, 0);

        for (int i = 0; i < 16; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // Stall: load 3C, hold it with f_ready low while req1 waits.
        apply(mk(0, 1, 0, 8'h3C, 8'h00, 0, 1, 0, 1, 0, 8'h22, 0), "st0");
        for (int i = 0; i < 3; i++)
            apply(mk(0, 0, 1, 8'h00, 8'h5A, 0, 0, 0, 0, 0, 8'h3C, 1),
                  $sformatf("st%0d", i + 1));
        apply(mk(0, 0, 1, 8'h00, 8'h5A, 1, 0, 1, 1, 1, 8'h3C, 1), "st4");

        // Pulsed req0 while stalled is dropped without a grant.
        apply(mk(0, 1, 0, 8'h99, 8'h00, 0, 0, 0, 0, 0, 8'h5A, 1), "dr0");
        apply(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h5A, 1), "dr1");
        apply(mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h5A, 1), "dr2");
        apply(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h5A, 0), "dr3");

        // Reset in the grant cycle wins; first tie afterwards goes to 0.
        apply(mk(0, 1, 0, 8'h44, 8'h00, 1, 1, 0, 1, 0, 8'h5A, 0), "rs0");
        apply(mk(1, 0, 1, 8'h00, 8'h7E, 1, 0, 0, 0, 0, 8'h44, 1), "rs1");
        apply(mk(0, 1, 1, 8'h10, 8'h20, 1, 1, 0, 1, 0, 8'h00, 0), "rs2");
        apply(mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 8'h10, 1), "rs3");

        // Random phase: start from a known reset.
        apply(mk(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 8'h10, 0), "rr");
        mq.delete();
        m_f = 8'h00;
        m_last = 1'b1;
        for (int c = 0; c < 400; c++) begin
            logic       rs, a0, a1, rdy, e_en, e_win, busy;
            logic [7:0] d0, d1;
            rs  = ($urandom_range(0, 29) == 0);
            a0  = $urandom_range(0, 1);
            a1  = $urandom_range(0, 1);
            rdy = ($urandom_range(0, 3) != 0);
            d0  = 8'($urandom);
            d1  = 8'($urandom);
            @(posedge clk);
            #1;
            reset = rs; req0 = a0; req1 = a1;
            w0 = d0; w1 = d1; f_ready = rdy;
            busy  = (mq.size() != 0);
            e_en  = !rs && (a0 || a1) && (!busy || rdy);
            e_win = (a0 && a1) ? !m_last : a1;
            @(negedge clk);
            chk("rnd.en", {7'd0, en}, {7'd0, e_en});
            chk("rnd.gnt0", {7'd0, gnt0}, {7'd0, e_en && !e_win});
            chk("rnd.gnt1", {7'd0, gnt1}, {7'd0, e_en && e_win});
            chk("rnd.sel", {7'd0, sel}, {7'd0, e_en && e_win});
            chk("rnd.f_valid", {7'd0, f_valid}, {7'd0, busy});
            if (busy) chk("rnd.f", f, mq[0]);
            else chk("rnd.f_hold", f, m_f);
            // Advance the model across the coming edge.
            if (rs) begin
                mq.delete();
                m_f = 8'h00;
                m_last = 1'b1;
            end else begin
                if (busy && rdy) void'(mq.pop_front());
                if (e_en) begin
                    m_f = e_win ? d1 : d0;
                    m_last = e_win;
                    mq.push_back(m_f);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    always @(negedge clk) begin
        if (gnt0 && gnt1) begin
            errors++;
            $display("FAIL dual_grant at %0t: got 11 expected not both", $time);
        end
    end

endmodule

// File: doc/mux2_arbiter.md
MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 3: the data word width is 2**N bits (8 at default).
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 req0  input  1  requester 0 has a word pending on w0.
REQ-005 req1  input  1  requester 1 has a word pending on w1.
REQ-006 w0  input  2**N  requester 0 data; held stable while req0 is high and gnt0 is low.
REQ-007 w1  input  2**N  requester 1 data; held stable while req1 is high and gnt1 is low.
REQ-008 gnt0  output  1  one-cycle acknowledge: w0 is captured at this clock edge.
REQ-009 gnt1  output  1  one-cycle acknowledge: w1 is captured at this clock edge.
REQ-010 sel  output  1  mux select in the current cycle (0 = w0, 1 = w1); meaningful only when en = 1.
REQ-011 en  output  1  mux enable and load strobe for the output register in the current cycle.
REQ-012 f  output  2**N  registered output word.
REQ-013 f_valid  output  1  f holds an undelivered word.
REQ-014 f_ready  input  1  downstream accepts f; a transfer occurs when f_valid and f_ready are both 1.

Function
REQ-015 The block SHALL contain a one-entry output register (f, f_valid) with two FSM states: EMPTY (f_valid = 0) and FULL (f_valid = 1).
REQ-016 can_load SHALL be (state == EMPTY) or (state == FULL and f_ready = 1), evaluated combinationally.
REQ-017 en SHALL be (req0 or req1) and can_load, evaluated combinationally.
REQ-018 Winner selection:
  - only req0 high: winner = 0
  - only req1 high: winner = 1
  - both high: winner = the requester other than last (round-robin).
REQ-019 sel SHALL equal the winner whenever en = 1, and SHALL be 0 when en = 0.
REQ-020 gnt0 SHALL be (en and winner == 0); gnt1 SHALL be (en and winner == 1); both SHALL be combinational; gnt0 and gnt1 SHALL never be high in the same cycle.
REQ-021 On an edge with en = 1:
  - f <= w0 when sel = 0, w1 when sel = 1
  - f_valid <= 1
  - last <= sel
  - next state FULL.
REQ-022 On an edge with en = 0 and a transfer (f_valid and f_ready): f_valid <= 0, next state EMPTY, f unchanged.
REQ-023 On an edge with en = 0 and no transfer, f, f_valid and last SHALL hold.
REQ-024 Simultaneous drain and load in FULL: the new word replaces f, f_valid stays 1, and no bubble is inserted.
REQ-025 In FULL with f_ready = 0: en, gnt0 and gnt1 SHALL be 0, and f SHALL stay stable until accepted.
REQ-026 f_ready while EMPTY SHALL be ignored.
REQ-027 A request dropped before its grant SHALL be discarded without effect; a requester holding req high after its grant presents a new word on the next cycle.
REQ-028 Latency: a request in cycle t with can_load = 1 SHALL see the grant in cycle t and f_valid with the word in cycle t+1.
REQ-029 Under continuous dual requests and f_ready = 1, grants SHALL alternate every cycle at a throughput of one word per cycle.

Reset
REQ-030 reset SHALL have priority over all other inputs.
REQ-031 Register values on reset:
  - f = 0, f_valid = 0
  - state = EMPTY
  - last = 1, so requester 0 wins the first tie.
REQ-032 While reset is high, gnt0, gnt1, en and sel SHALL be 0.
REQ-033 Reset mid-operation SHALL discard any word held in f; requesters SHALL re-arbitrate from the reset state.

Verification
REQ-034 Reset, then req0 = 1, w0 = 8'hA5 for one cycle, f_ready = 1 -> gnt0 = 1 in that cycle; the next cycle f = 8'hA5, f_valid = 1; f_valid = 0 one cycle later.
REQ-035 After reset, req0 = req1 = 1 held for 4 cycles, w0 = 8'h11, w1 = 8'h22, f_ready = 1 -> grant order 0,1,0,1; f sequence 11,22,11,22 with no bubbles.
REQ-036 FULL with f = 8'h3C, f_ready = 0 for 3 cycles, req1 = 1 -> gnt1 = 0 and f = 8'h3C throughout; f_ready = 1 -> gnt1 = 1 the same cycle, f = w1 next cycle.
REQ-037 req1 = 1, w1 = 8'h7E, then reset asserted in the grant cycle -> f = 0, f_valid = 0 the next cycle, no grant observed; after release, the first tie goes to requester 0.
REQ-038 f_ready = 1 with no requests from reset for 5 cycles -> f_valid, en and both grants stay 0.
REQ-039 req0 pulsed high while FULL and stalled, then dropped -> no gnt0, and f/f_valid unaffected.
